// File: rtl/am_ctrl_pkg.sv
// ============================================================================
// Package   : am_ctrl_pkg
// Purpose   : Shared constants and helpers for the AM frame sequencer slice.
//             It holds the FSM state encoding, the default widths, the mark
//             level, and the number of symbol bits per payload byte.
// Macro     : AM_FRAME_PARITY_EN adds an even-parity bit after each byte.
//             This makes 9 symbol bits per byte instead of 8.
// Revision  : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package am_ctrl_pkg;

  localparam int DEPTH_W_DEF  = 9;
  localparam int PERIOD_W_DEF = 32;

  // Idle level of the symbol line.
  localparam logic MARK = 1'b1;

`ifdef AM_FRAME_PARITY_EN
  localparam int BITS_PER_BYTE = 9;
`else
  localparam int BITS_PER_BYTE = 8;
`endif

  // FSM state encoding.
  typedef logic [1:0] am_state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_SEND      = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  // Word loaded into the shifter for one payload byte, MSB sent first.
  function automatic logic [BITS_PER_BYTE-1:0] frame_word(input logic [7:0] b);
`ifdef AM_FRAME_PARITY_EN
    return {b, ^b};
`else
    return b;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/am_ramp_gen.sv
// ============================================================================
// Module    : am_ramp_gen
// Purpose   : Ramp tick divider plus a saturating up/down depth register.
// Ports     : clk_200M, rst_n (async, active-low)
//             up/down   - ramp direction enables; the divider runs while
//                         either enable is high and is cleared otherwise
//             step, max - increment per tick and the upper limit
//             depth     - registered depth word
//             at_max, at_zero - depth limit flags
// Revision  : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module am_ramp_gen #(
  parameter int DEPTH_W  = 9,
  parameter int RAMP_DIV = 16
) (
  input  logic               clk_200M,
  input  logic               rst_n,
  input  logic               up,
  input  logic               down,
  input  logic [DEPTH_W-1:0] step,
  input  logic [DEPTH_W-1:0] max,
  output logic [DEPTH_W-1:0] depth,
  output logic               at_max,
  output logic               at_zero
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W:0]   sum;
  logic               tick;

  always_comb begin
    tick    = (up || down) && (div_q == DIV_LAST);
    div_d   = ((up || down) && !tick) ? div_q + 1'b1 : '0;
    // One extra bit, so the sum cannot wrap before it is clamped to max.
    sum     = {1'b0, depth_q} + {1'b0, step};
    depth_d = depth_q;
    if (tick && up) begin
      if ((step == '0) || (sum >= {1'b0, max})) depth_d = max;
      else                                      depth_d = sum[DEPTH_W-1:0];
    end else if (tick && down) begin
      if ((step == '0) || (step >= depth_q)) depth_d = '0;
      else                                   depth_d = depth_q - step;
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      depth_q <= '0;
    end else begin
      div_q   <= div_d;
      depth_q <= depth_d;
    end
  end

  assign depth   = depth_q;
  assign at_max  = (depth_q == max);
  assign at_zero = (depth_q == '0);

endmodule

`default_nettype wire

// File: rtl/am_frame_seq.sv
// ============================================================================
// Module    : am_frame_seq
// Purpose   : Frame sequencer for the ASK/AM modulator (200 MHz domain).
//             It takes payload bytes through a one-entry holding register and
//             shifts them out MSB-first on binary_data. It ramps the depth
//             word up before the payload and back down after the payload.
// Ports     : clk_200M, rst_n (async assert, active-low)
//             cfg_bit_period/cfg_depth_max/cfg_ramp_step - latched at frame start
//             byte_data/byte_valid/byte_ready - payload handshake
//             depth, binary_data, busy, frame_done - registered outputs
// Macro     : AM_FRAME_PARITY_EN appends an even-parity bit to each byte.
// Revision  : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module am_frame_seq
  import am_ctrl_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF,
  parameter int RAMP_DIV = 16
) (
  input  logic                clk_200M,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] cfg_bit_period,
  input  logic [DEPTH_W-1:0]  cfg_depth_max,
  input  logic [DEPTH_W-1:0]  cfg_ramp_step,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [DEPTH_W-1:0]  depth,
  output logic                binary_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_BYTE - 1);

  am_state_t                state_q, state_d;
  logic [7:0]               hold_q, hold_d;
  logic                     hold_valid_q, hold_valid_d;
  logic                     byte_ready_q, byte_ready_d;
  logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
  logic [PERIOD_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PERIOD_W-1:0]      period_q, period_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [DEPTH_W-1:0]       depth_max_q, depth_max_d;
  logic [DEPTH_W-1:0]       step_q, step_d;
  logic                     binary_data_q, binary_data_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     xfer, load, at_max, at_zero;

  am_ramp_gen #(
    .DEPTH_W  (DEPTH_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk_200M (clk_200M),
    .rst_n    (rst_n),
    .up       (state_q == ST_RAMP_UP),
    .down     (state_q == ST_RAMP_DOWN),
    .step     (step_q),
    .max      (depth_max_q),
    .depth    (depth),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    period_d     = period_q;
    bit_idx_d    = bit_idx_q;
    depth_max_d  = depth_max_q;
    step_d       = step_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    xfer         = byte_valid && byte_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q) begin
          period_d    = cfg_bit_period;
          depth_max_d = cfg_depth_max;
          step_d      = cfg_ramp_step;
          state_d     = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (at_max) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_cnt_q == period_q) begin
          bit_cnt_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            // A queued byte continues the frame with no gap and no depth change.
            if (hold_valid_q) begin
              load      = 1'b1;
              bit_idx_d = '0;
            end else begin
              state_d = ST_RAMP_DOWN;
            end
          end else begin
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        if (at_zero) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
    endcase

    if (load) shift_d = frame_word(hold_q);

    // A transfer only happens while the holding register is empty.
    // A load only happens while it is full. So the two never collide.
    if (xfer) begin
      hold_d       = byte_data;
      hold_valid_d = 1'b1;
    end else if (load) begin
      hold_valid_d = 1'b0;
    end

    byte_ready_d  = !hold_valid_d;
    binary_data_d = (state_d == ST_SEND) ? shift_d[BITS_PER_BYTE-1] : MARK;
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      byte_ready_q  <= 1'b1;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      period_q      <= '0;
      bit_idx_q     <= '0;
      depth_max_q   <= '0;
      step_q        <= '0;
      binary_data_q <= MARK;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      byte_ready_q  <= byte_ready_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      period_q      <= period_d;
      bit_idx_q     <= bit_idx_d;
      depth_max_q   <= depth_max_d;
      step_q        <= step_d;
      binary_data_q <= binary_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign byte_ready  = byte_ready_q;
  assign binary_data = binary_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_am_frame_seq.sv
// ============================================================================
// Module    : tb_am_frame_seq
// Purpose   : Scoreboard testbench for am_frame_seq. Each stimulus step
//             queues the expected depth steps and the expected symbol stream.
//             The monitor pops and compares them when the DUT shows a depth
//             change or a frame_done pulse.
// Revision  : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_am_frame_seq;

  localparam int PERIOD_W = 32;
  localparam int DEPTH_W  = 9;
  localparam int RAMP_DIV = 16;
`ifdef AM_FRAME_PARITY_EN
  localparam int TB_BITS = 9;
`else
  localparam int TB_BITS = 8;
`endif

  logic                clk_200M = 1'b0;
  logic                rst_n    = 1'b0;
  logic [PERIOD_W-1:0] cfg_bit_period = '0;
  logic [DEPTH_W-1:0]  cfg_depth_max  = '0;
  logic [DEPTH_W-1:0]  cfg_ramp_step  = '0;
  logic [7:0]          byte_data  = '0;
  logic                byte_valid = 1'b0;
  logic                byte_ready;
  logic [DEPTH_W-1:0]  depth;
  logic                binary_data;
  logic                busy;
  logic                frame_done;

  always #2.5 clk_200M = ~clk_200M;

  am_frame_seq #(
    .PERIOD_W (PERIOD_W),
    .DEPTH_W  (DEPTH_W),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk_200M       (clk_200M),
    .rst_n          (rst_n),
    .cfg_bit_period (cfg_bit_period),
    .cfg_depth_max  (cfg_depth_max),
    .cfg_ramp_step  (cfg_ramp_step),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .depth          (depth),
    .binary_data    (binary_data),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  typedef struct {
    int           dmax;
    int           len;
    logic [511:0] bits;
  } frame_t;

  typedef struct {
    int val;
    int gap;   // cycles since previous depth change; 0 = not checked
  } dep_t;

  frame_t exp_frames[$];
  dep_t   exp_depth[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input bit ok, input longint got, input longint want);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  function automatic logic [TB_BITS-1:0] tb_word(input logic [7:0] b);
`ifdef AM_FRAME_PARITY_EN
    return {b, ^b};
`else
    return b;
`endif
  endfunction

  // Cycles that depth sits at max: 1 mark cycle, the payload, and 1 ramp tick of mark.
  function automatic int hold_gap(input int period, input int nb);
    return 1 + nb * TB_BITS * (period + 1) + RAMP_DIV;
  endfunction

  task automatic push_depth(input int val, input int gap);
    dep_t e;
    e.val = val;
    e.gap = gap;
    exp_depth.push_back(e);
  endtask

  task automatic push_frame(input int dmax, input int period, input int nb,
                            input logic [7:0] b0, input logic [7:0] b1);
    frame_t             f;
    logic [TB_BITS-1:0] w;
    int                 k;
    f.dmax = dmax;
    f.bits = '0;
    k = 0;
    f.bits[k] = 1'b1; k++;
    for (int j = 0; j < nb; j++) begin
      w = tb_word((j == 0) ? b0 : b1);
      for (int i = TB_BITS - 1; i >= 0; i--)
        for (int r = 0; r <= period; r++) begin
          f.bits[k] = w[i]; k++;
        end
    end
    for (int r = 0; r < RAMP_DIV; r++) begin
      f.bits[k] = 1'b1; k++;
    end
    f.len = k;
    exp_frames.push_back(f);
  endtask

  task automatic set_cfg(input int period, input int dmax, input int step);
    cfg_bit_period = PERIOD_W'(period);
    cfg_depth_max  = DEPTH_W'(dmax);
    cfg_ramp_step  = DEPTH_W'(step);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_200M);
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 3000) begin
      @(negedge clk_200M);
      n++;
    end
    if (!byte_ready) chk("byte_accept_timeout", 1'b0, 0, 1);
    @(posedge clk_200M);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_frames.size() > 0 || exp_depth.size() > 0) && n < 4000) begin
      @(negedge clk_200M);
      n++;
    end
    chk("frame_timeout", (exp_frames.size() == 0) && (exp_depth.size() == 0),
        exp_frames.size() + exp_depth.size(), 0);
    repeat (3) @(negedge clk_200M);
  endtask

  // ---------------------------------------------------------------- monitor
  bit           mon_en = 1'b0;
  bit           fd_prev = 1'b0;
  logic [511:0] cap;
  int           cap_len = 0;
  int           prev_depth = 0;
  int           last_chg = 0;
  int           cyc = 0;

  always @(negedge clk_200M) begin : mon
    frame_t f;
    dep_t   e;
    cyc++;
    if (!mon_en) begin
      prev_depth = int'(depth);
      last_chg   = cyc;
      cap        = '0;
      cap_len    = 0;
      fd_prev    = 1'b0;
    end else begin
      if (int'(depth) != prev_depth) begin
        if (exp_depth.size() == 0) begin
          chk("depth_unexpected", 1'b0, depth, -1);
        end else begin
          e = exp_depth.pop_front();
          chk("depth_value", int'(depth) == e.val, depth, e.val);
          if (e.gap != 0) chk("depth_tick_gap", (cyc - last_chg) == e.gap, cyc - last_chg, e.gap);
        end
        prev_depth = int'(depth);
        last_chg   = cyc;
      end
      if (exp_frames.size() > 0 && busy && int'(depth) == exp_frames[0].dmax && cap_len < 512) begin
        cap[cap_len] = binary_data;
        cap_len++;
      end
      if (frame_done) begin
        chk("frame_done_width", !fd_prev, 2, 1);
        if (exp_frames.size() == 0) begin
          chk("frame_done_unexpected", 1'b0, 1, 0);
        end else begin
          f = exp_frames.pop_front();
          chk("stream_len", cap_len == f.len, cap_len, f.len);
          n_total++;
          if (cap == f.bits) n_pass++;
          else $display("FAIL stream: got %h expected %h", cap[127:0], f.bits[127:0]);
          chk("idle_after_done", !busy && depth == '0, {busy, depth}, 0);
        end
        cap     = '0;
        cap_len = 0;
      end
      fd_prev = frame_done;
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    #10;
    chk("rst_depth",       depth == '0,      depth,       0);
    chk("rst_binary_data", binary_data == 1'b1, binary_data, 1);
    chk("rst_busy",        busy == 1'b0,     busy,        0);
    chk("rst_byte_ready",  byte_ready == 1'b1, byte_ready, 1);
    chk("rst_frame_done",  frame_done == 1'b0, frame_done, 0);
    @(negedge clk_200M);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_200M);

    // Reset in the middle of SEND, with a second byte waiting in the holding register.
    set_cfg(3, 180, 60);
    send_byte(8'hA5);
    send_byte(8'h5A);
    repeat (13) @(negedge clk_200M);
    chk("pre_reset_busy", busy == 1'b1, busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_depth",       depth == '0,        depth,       0);
    chk("async_rst_binary_data", binary_data == 1'b1, binary_data, 1);
    chk("async_rst_busy",        busy == 1'b0,       busy,        0);
    chk("async_rst_byte_ready",  byte_ready == 1'b1, byte_ready,  1);
    @(negedge clk_200M);
    rst_n = 1'b1;
    repeat (80) @(negedge clk_200M);
    chk("held_byte_dropped_busy",  busy == 1'b0,  busy,  0);
    chk("held_byte_dropped_depth", depth == '0,   depth, 0);
    mon_en = 1'b1;
    @(negedge clk_200M);

    // Single frame 0xA5; the config is changed mid-frame and must be ignored.
    set_cfg(3, 180, 60);
    push_depth(60, 0);  push_depth(120, 16); push_depth(180, 16);
    push_depth(120, hold_gap(3, 1)); push_depth(60, 16); push_depth(0, 16);
    push_frame(180, 3, 1, 8'hA5, 8'h00);
    send_byte(8'hA5);
    repeat (3) @(negedge clk_200M);
    set_cfg(7, 50, 1);
    wait_done();

    // Two bytes back-to-back in a single frame.
    set_cfg(3, 180, 60);
    push_depth(60, 0);  push_depth(120, 16); push_depth(180, 16);
    push_depth(120, hold_gap(3, 2)); push_depth(60, 16); push_depth(0, 16);
    push_frame(180, 3, 2, 8'h0F, 8'hF0);
    send_byte(8'h0F);
    send_byte(8'hF0);
    wait_done();

    // Saturation at full scale without wraparound.
    set_cfg(1, 511, 200);
    push_depth(200, 0); push_depth(400, 16); push_depth(511, 16);
    push_depth(311, hold_gap(1, 1)); push_depth(111, 16); push_depth(0, 16);
    push_frame(511, 1, 1, 8'h3C, 8'h00);
    send_byte(8'h3C);
    wait_done();

    // Step 0 jumps straight to the limit; period 0 sends one cycle per bit.
    set_cfg(0, 100, 0);
    push_depth(100, 0); push_depth(0, hold_gap(0, 1));
    push_frame(100, 0, 1, 8'h96, 8'h00);
    send_byte(8'h96);
    wait_done();

`ifdef AM_FRAME_PARITY_EN
    set_cfg(1, 180, 60);
    push_depth(60, 0);  push_depth(120, 16); push_depth(180, 16);
    push_depth(120, hold_gap(1, 1)); push_depth(60, 16); push_depth(0, 16);
    push_frame(180, 1, 1, 8'h07, 8'h00);
    send_byte(8'h07);
    wait_done();
    push_depth(60, 0);  push_depth(120, 16); push_depth(180, 16);
    push_depth(120, hold_gap(1, 1)); push_depth(60, 16); push_depth(0, 16);
    push_frame(180, 1, 1, 8'h03, 8'h00);
    send_byte(8'h03);
    wait_done();
`endif

    repeat (20) @(negedge clk_200M);
    chk("final_idle", !busy && byte_ready, {busy, byte_ready}, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
